// File: rtl/result_fmt_pkg.sv
// Purpose: shared state enum, job record, ASCII constants and digit helpers for result_formatter.
// Latency: none (declarations and pure functions only).
// Backpressure: none.
package result_fmt_pkg;

    localparam int RES_W      = 32;
    localparam int BCD_W      = 40;
    localparam int DIGITS_DEC = 10;
    localparam int DIGITS_HEX = 8;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SEND,
        CR,
        LF
    } fmt_state_e;

    // One captured formatting request.
    typedef struct packed {
        logic             hex;
        logic             neg;
        logic [RES_W-1:0] res;
    } fmt_job_t;

    // Index of the most significant non-zero digit; 0 when every digit is zero,
    // so a zero value still prints a single '0'.
    function automatic logic [3:0] lead_idx(input logic [BCD_W-1:0] d, input logic is_hex);
        logic [3:0] idx;
        int         ndig;
        idx  = 4'd0;
        ndig = is_hex ? DIGITS_HEX : DIGITS_DEC;
        for (int i = 0; i < DIGITS_DEC; i++) begin
            if ((i < ndig) && (d[i*4 +: 4] != 4'd0)) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Digit to ASCII; 10-15 map to uppercase 'A'-'F'.
    function automatic logic [7:0] digit_ascii(input logic [3:0] n);
        logic [7:0] c;
        if (n < 4'd10) begin
            c = ASCII_ZERO + {4'd0, n};
        end else begin
            c = ASCII_A + {4'd0, n} - 8'd10;
        end
        return c;
    endfunction

endpackage

// File: rtl/result_formatter_if.sv
// Purpose: ALU-result input and UART TX byte stream of the result formatter, plus status.
// Latency: none (wiring only).
// Backpressure: tx_valid/tx_ready; alu_done has no backpressure and is dropped while busy.
interface result_formatter_if;
    import result_fmt_pkg::*;

    logic             alu_done;
    logic [RES_W-1:0] calc_res;
    logic [3:0]       dtype;
    logic             tx_ready;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             fmt_busy;
    logic             fmt_done;

    // Environment side: ALU and UART TX.
    modport master (
        output alu_done, calc_res, dtype, tx_ready,
        input  tx_valid, tx_data, fmt_busy, fmt_done
    );

    // Formatter side.
    modport slave (
        input  alu_done, calc_res, dtype, tx_ready,
        output tx_valid, tx_data, fmt_busy, fmt_done
    );

endinterface

// File: rtl/result_formatter_bin2bcd_iter.sv
// Purpose: iterative double-dabble, 32-bit binary to 10 BCD digits, one bit per cycle.
// Latency: start sampled at edge 0, 32 shift edges, done pulses in the cycle after the last shift.
// Backpressure: none; a new start restarts the conversion, result holds until the next start.
module bin2bcd_iter
    import result_fmt_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [RES_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    logic [RES_W-1:0] sh_q;
    logic [BCD_W-1:0] bcd_q;
    logic [4:0]       cnt_q;
    logic             run_q;
    logic             done_q;
    logic [BCD_W-1:0] bcd_adj;

    // Add 3 to every digit of 5 or more so the following left shift carries correctly.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS_DEC; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift one binary bit into the BCD register per cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            sh_q   <= bin;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            sh_q   <= {sh_q[RES_W-2:0], 1'b0};
            bcd_q  <= {bcd_adj[BCD_W-2:0], sh_q[RES_W-1]};
            cnt_q  <= cnt_q + 5'd1;
            run_q  <= (cnt_q != 5'd31);
            done_q <= (cnt_q == 5'd31);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign bcd  = bcd_q;
    assign done = done_q;

endmodule

// File: rtl/result_formatter.sv
// Purpose: formats each ALU result as an ASCII decimal/hex line ending in CR LF; RESULT_FMT_SIGNED_EN enables signed decimal.
// Latency: first byte 34 cycles after alu_done (decimal) or 3 cycles (hex); then one byte per accepted cycle.
// Backpressure: holds tx_valid/tx_data until tx_ready; alu_done while busy (or in the fmt_done cycle) is dropped.
module result_formatter
    import result_fmt_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    result_formatter_if.slave  bus
);

    fmt_state_e       state_q;
    fmt_state_e       state_d;
    fmt_job_t         job_q;
    logic [BCD_W-1:0] dig_q;
    logic [3:0]       idx_q;
    logic             minus_q;
    logic             hex_ld_q;
    logic             done_q;

    logic             accept;
    logic             neg_in;
    logic [RES_W-1:0] mag;
    logic             bcd_start;
    logic             bcd_done;
    logic [BCD_W-1:0] bcd_val;
    logic             sel_go;
    logic [BCD_W-1:0] sel_src;
    logic [BCD_W-1:0] dig_sh;
    logic [3:0]       cur_nib;

    logic             hex_load;
    logic             sel_take;
    logic             idx_dec;
    logic             minus_clr;
    logic             lf_xfer;
    logic             out_vld;
    logic [7:0]       out_dat;
    logic             unused_dtype;

    // A request is taken only in IDLE and never in the cycle fmt_done is pulsing.
    assign accept = (state_q == IDLE) && bus.alu_done && !done_q;

`ifdef RESULT_FMT_SIGNED_EN
    assign neg_in = !bus.dtype[0] && bus.calc_res[RES_W-1];
`else
    assign neg_in = 1'b0;
`endif

    assign mag          = neg_in ? (~bus.calc_res + 32'd1) : bus.calc_res;
    assign bcd_start    = accept && !bus.dtype[0];
    assign unused_dtype = ^bus.dtype[3:1];

    bin2bcd_iter u_bin2bcd (
        .clk   (clk),
        .n_rst (n_rst),
        .start (bcd_start),
        .bin   (mag),
        .bcd   (bcd_val),
        .done  (bcd_done)
    );

    // Digits are ready for leading-zero selection once the BCD finishes or the hex nibbles are loaded.
    assign sel_go  = job_q.hex ? hex_ld_q : bcd_done;
    assign sel_src = job_q.hex ? dig_q : bcd_val;
    assign dig_sh  = dig_q >> {idx_q, 2'b00};
    assign cur_nib = dig_sh[3:0];

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, TX byte mux and datapath strobes.
    always_comb begin
        state_d   = state_q;
        out_vld   = 1'b0;
        out_dat   = 8'h00;
        hex_load  = 1'b0;
        sel_take  = 1'b0;
        idx_dec   = 1'b0;
        minus_clr = 1'b0;
        lf_xfer   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                if (job_q.hex && !hex_ld_q) begin
                    hex_load = 1'b1;
                end
                if (sel_go) begin
                    sel_take = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                out_vld = 1'b1;
                if (minus_q) begin
                    out_dat = ASCII_MINUS;
                    if (bus.tx_ready) begin
                        minus_clr = 1'b1;
                    end
                end else begin
                    out_dat = digit_ascii(cur_nib);
                    if (bus.tx_ready) begin
                        if (idx_q == 4'd0) begin
                            state_d = CR;
                        end else begin
                            idx_dec = 1'b1;
                        end
                    end
                end
            end
            CR: begin
                out_vld = 1'b1;
                out_dat = ASCII_CR;
                if (bus.tx_ready) begin
                    state_d = LF;
                end
            end
            LF: begin
                out_vld = 1'b1;
                out_dat = ASCII_LF;
                if (bus.tx_ready) begin
                    lf_xfer = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture, digit buffer, digit index and sign tracking.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            job_q    <= '0;
            dig_q    <= '0;
            idx_q    <= '0;
            minus_q  <= 1'b0;
            hex_ld_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= lf_xfer;
            if (accept) begin
                job_q.res <= bus.calc_res;
                job_q.hex <= bus.dtype[0];
                job_q.neg <= neg_in;
                hex_ld_q  <= 1'b0;
                minus_q   <= 1'b0;
            end
            if (hex_load) begin
                dig_q    <= {{(BCD_W-RES_W){1'b0}}, job_q.res};
                hex_ld_q <= 1'b1;
            end
            if (sel_take) begin
                dig_q   <= sel_src;
                idx_q   <= lead_idx(sel_src, job_q.hex);
                minus_q <= job_q.neg;
            end
            if (idx_dec) begin
                idx_q <= idx_q - 4'd1;
            end
            if (minus_clr) begin
                minus_q <= 1'b0;
            end
        end
    end

    assign bus.tx_valid = out_vld;
    assign bus.tx_data  = out_dat;
    assign bus.fmt_busy = (state_q != IDLE);
    assign bus.fmt_done = done_q;

endmodule

// File: tb/tb_result_formatter.sv
// Purpose: directed bench for result_formatter; expected bytes queued at stimulus, popped on each TX transfer.
// Latency: checks first-byte latency (34 decimal / 3 hex) and back-to-back streaming.
// Backpressure: random tx_ready stalls with data/valid hold checks.
module tb_result_formatter;

    logic clk;
    logic n_rst;
    int   checks;
    int   failures;
    logic [7:0] exp_q[$];

    result_formatter_if bus();

    result_formatter dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference text of a line, built independently of the DUT's digit logic.
    task automatic push_line(input logic [31:0] v, input bit hex);
        string s;
        string hexch;
        bit    lead;
        int    n;
        hexch = "0123456789ABCDEF";
        s     = "";
        if (hex) begin
            lead = 1'b1;
            for (int i = 7; i >= 0; i--) begin
                n = int'((v >> (i * 4)) & 32'hF);
                if (n != 0 || !lead || i == 0) begin
                    lead = 1'b0;
                    s = {s, hexch.substr(n, n)};
                end
            end
        end else begin
`ifdef RESULT_FMT_SIGNED_EN
            s = $sformatf("%0d", $signed(v));
`else
            s = $sformatf("%0d", v);
`endif
        end
        for (int i = 0; i < s.len(); i++) begin
            exp_q.push_back(s[i]);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Pulse alu_done for one cycle starting at the current negedge.
    task automatic start_line(input logic [31:0] v, input bit hex);
        bus.alu_done = 1'b1;
        bus.calc_res = v;
        bus.dtype    = {3'b101, hex};
        @(negedge clk);
        bus.alu_done = 1'b0;
        bus.calc_res = $urandom;
    endtask

    // Consume the DUT byte stream at negedges until fmt_done, the budget, or abort_bytes transfers.
    task automatic drain(input int budget, input bit rnd, input int inject_at, input int abort_bytes,
                         output int first_k, output int done_k);
        int         k;
        int         popped;
        bit         stalled;
        bit         fin;
        bit         aborted;
        logic [7:0] held;
        k = 1; popped = 0; stalled = 1'b0; fin = 1'b0; aborted = 1'b0; held = 8'h00;
        first_k = -1;
        done_k  = -1;
        while (!fin && !aborted && k <= budget) begin
            if (bus.fmt_done) begin
                fin    = 1'b1;
                done_k = k;
                chk("queue_empty_at_done", exp_q.size(), 0);
                chk("busy_low_at_done", bus.fmt_busy, 0);
            end else begin
                if (k == inject_at) begin
                    bus.alu_done = 1'b1;
                    bus.calc_res = 32'd7;
                    bus.dtype    = 4'd0;
                end else begin
                    bus.alu_done = 1'b0;
                end
                if (stalled) begin
                    chk("hold_valid", bus.tx_valid, 1);
                    chk("hold_data", bus.tx_data, held);
                end
                bus.tx_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (bus.tx_valid && first_k < 0) begin
                    first_k = k;
                end
                if (bus.tx_valid && bus.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", bus.tx_data, 32'hFFFF_FFFF);
                    end else begin
                        chk("byte", bus.tx_data, exp_q.pop_front());
                    end
                    popped++;
                    stalled = 1'b0;
                end else begin
                    stalled = bus.tx_valid;
                end
                held = bus.tx_data;
                @(negedge clk);
                k++;
                if (popped == abort_bytes) begin
                    aborted = 1'b1;
                end
            end
        end
        bus.alu_done = 1'b0;
        bus.tx_ready = 1'b1;
        if (abort_bytes < 0) begin
            chk("line_done", fin, 1);
        end
    endtask

    task automatic run_line(input logic [31:0] v, input bit hex, input bit rnd,
                            input int inject_at, input int exp_lat);
        int fk;
        int dk;
        int nb;
        push_line(v, hex);
        nb = exp_q.size();
        start_line(v, hex);
        chk("busy_after_accept", bus.fmt_busy, 1);
        drain(400, rnd, inject_at, -1, fk, dk);
        chk("first_valid_latency", fk, exp_lat);
        if (!rnd) begin
            chk("back_to_back", dk - fk, nb);
        end
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_valid", bus.tx_valid, 0);
            chk("idle_busy", bus.fmt_busy, 0);
            chk("idle_done", bus.fmt_done, 0);
        end
    endtask

    initial begin
        int fk;
        int dk;
        checks   = 0;
        failures = 0;
        n_rst        = 1'b0;
        bus.alu_done = 1'b0;
        bus.calc_res = 32'd0;
        bus.dtype    = 4'd0;
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_busy", bus.fmt_busy, 0);
        chk("rst_done", bus.fmt_done, 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Decimal lines with tx_ready held high.
        run_line(32'd0, 1'b0, 1'b0, -1, 34);
        idle_check(2);
        run_line(32'd12345, 1'b0, 1'b0, -1, 34);
        idle_check(1);
        run_line(32'hFFFF_FFFF, 1'b0, 1'b0, -1, 34);
        idle_check(1);
        run_line(32'h8000_0000, 1'b0, 1'b0, -1, 34);
        idle_check(1);
        run_line(32'd1000000000, 1'b0, 1'b0, -1, 34);
        idle_check(1);

        // Hex lines, including random stalls.
        run_line(32'h00AB_CDEF, 1'b1, 1'b1, -1, 3);
        idle_check(1);
        run_line(32'h00AB_CDEF, 1'b1, 1'b0, -1, 3);
        idle_check(1);
        run_line(32'd0, 1'b1, 1'b0, -1, 3);
        idle_check(1);
        run_line(32'hFFFF_FFFF, 1'b1, 1'b0, -1, 3);
        idle_check(1);
        run_line(32'h0000_0010, 1'b1, 1'b0, -1, 3);
        idle_check(1);
        run_line(32'd987654321, 1'b0, 1'b1, -1, 34);
        idle_check(1);

        // alu_done (value 7) during the 999 line must be dropped.
        run_line(32'd999, 1'b0, 1'b0, 35, 34);
        idle_check(4);

        // alu_done in the fmt_done cycle is dropped; the next cycle is accepted.
        run_line(32'd5, 1'b0, 1'b0, -1, 34);
        bus.alu_done = 1'b1;
        bus.calc_res = 32'd77;
        bus.dtype    = 4'd0;
        @(negedge clk);
        bus.alu_done = 1'b0;
        chk("done_cycle_alu_done_dropped", bus.fmt_busy, 0);
        run_line(32'd42, 1'b0, 1'b0, -1, 34);
        idle_check(1);

        // Reset after two bytes of "12345" aborts the line without CR/LF.
        push_line(32'd12345, 1'b0);
        start_line(32'd12345, 1'b0);
        drain(400, 1'b0, -1, 2, fk, dk);
        chk("abort_mid_line_valid", bus.tx_valid, 1);
        n_rst = 1'b0;
        #1;
        chk("abort_rst_tx_valid", bus.tx_valid, 0);
        chk("abort_rst_tx_data", bus.tx_data, 8'h00);
        chk("abort_rst_busy", bus.fmt_busy, 0);
        chk("abort_rst_done", bus.fmt_done, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        idle_check(3);
        run_line(32'd42, 1'b0, 1'b0, -1, 34);
        idle_check(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_formatter.md
# result_formatter

Converts each 32-bit ALU result into an ASCII line and streams it byte-by-byte to the UART transmitter, terminating every line with CR LF. Sits between the ALU (`alu_done`/`calc_res`) and the UART TX front end, the return path of the calculator opposite the command parser. Decimal output uses an iterative double-dabble converter. Hex output is emitted directly from nibbles.

## Interface
- No parameters (widths fixed: 32-bit result, 8-bit bytes).
- `clk` input 1: system clock, rising edge.
- `n_rst` input 1: asynchronous, active-low reset.
- `alu_done` input 1: one-cycle pulse; `calc_res` and `dtype` are valid in that cycle.
- `calc_res` input 32: result to format.
- `dtype` input 4: output radix select; `dtype[0]`=0 decimal, 1 hex; bits [3:1] ignored.
- `tx_ready` input 1: UART TX can accept a byte.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_data` output 8: ASCII byte.
- `fmt_busy` output 1: line in progress; high from the cycle after accept until `fmt_done`.
- `fmt_done` output 1: one-cycle pulse after the LF byte transfers.

## Operation
- States: IDLE, CONV, SEND, CR, LF.
- IDLE: on `alu_done`=1, capture `calc_res` and radix, then go to CONV.
- CONV, decimal: 32 shift cycles of double dabble into 10 BCD digits. Then go to SEND.
- CONV, hex: 1 cycle to load 8 nibbles. Then go to SEND.
- SEND: emit digits MSB-first.
  - Suppress leading zeros; always emit at least one digit (value 0 -> "0").
  - Decimal digit d -> 0x30+d.
  - Hex nibble 0-9 -> 0x30+n; A-F -> 0x41+(n-10), uppercase.
  - No "0x" prefix.
- After the last digit transfers: CR (0x0D), then LF (0x0A), then IDLE.
- Handshake: a byte transfers in a cycle where `tx_valid`&&`tx_ready`=1.
  - `tx_data` stays stable and `tx_valid` stays high until the transfer.
  - `tx_ready` may stall indefinitely; there is no timeout.
- `alu_done` while not in IDLE is ignored; the result is dropped and the current line is unaffected.
- Maximum line length: 13 bytes ('-' + 10 digits + CR LF).

## Timing
- Reset values: `tx_valid`=0, `tx_data`=8'h00, `fmt_busy`=0, `fmt_done`=0; state IDLE; all capture and BCD registers cleared.
- Reset asserted mid-line aborts immediately. No partial CR/LF is sent, and the line is not resumed.
- Accept cycle = cycle N (`alu_done` high). `fmt_busy`=1 from N+1.
- Decimal: first `tx_valid` at N+34 (32 shift cycles + 1 load + 1 digit select).
- Hex: first `tx_valid` at N+3.
- With `tx_ready` held at 1: one byte per cycle, back-to-back, including CR and LF.
- `fmt_done` pulses in the cycle after the LF transfer. `fmt_busy` falls in that same cycle.
- An `alu_done` arriving in that same cycle is ignored. The first accepted `alu_done` is in the following cycle, in IDLE.

## Configuration
- `RESULT_FMT_SIGNED_EN` defined: in decimal mode `calc_res` is two's complement.
  - If bit 31=1, emit '-' (0x2D) first, then convert the magnitude (`~calc_res`+1).
  - 0x80000000 -> "-2147483648".
  - Hex mode is unaffected.
- Not defined: decimal is always unsigned; no '-' byte is ever produced.

## Structure
- Shared package `result_fmt_pkg`:
  - state enum (IDLE, CONV, SEND, CR, LF)
  - ASCII constants (zero, 'A', minus, CR, LF)
  - `DIGITS_DEC`=10, `DIGITS_HEX`=8
- One sub-module: `bin2bcd_iter`.
  - Interface: start pulse, 32-bit binary in, 40-bit BCD out, done pulse after 32 cycles.
  - Async active-low reset, same clock.
- Top level owns the FSM, leading-zero tracking, digit index counter and TX handshake.

## Test plan
- Decimal, `calc_res`=0, `tx_ready`=1 -> bytes 0x30,0x0D,0x0A; `fmt_done` once.
- Decimal, `calc_res`=12345 -> "12345\r\n"; first `tx_valid` exactly 34 cycles after `alu_done`.
- Decimal, `calc_res`=0xFFFFFFFF:
  - without the macro -> "4294967295\r\n";
  - with `RESULT_FMT_SIGNED_EN` -> "-1\r\n".
- Hex, `calc_res`=0x00ABCDEF -> "ABCDEF\r\n". Toggle `tx_ready` randomly -> `tx_data` stable while stalled; no bytes lost or duplicated.
- Second `alu_done` (value 7) mid-line while sending 999 -> only "999\r\n" is emitted.
- Assert `n_rst` after 2 bytes of "12345" -> outputs return to reset values immediately. Next `alu_done` (42) -> "42\r\n".
